fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
Sequencer for the instruction-fetch stage. It owns the PC and issues word requests to the instruction memory over a req/ready handshake. It applies redirect, stall and halt decisions from later stages, and drives the IF/ID pipeline register (instruction, PC+4, valid). It sits between the hazard/branch logic (MEM and ID stages) and the instruction memory, and replaces the free-running PC update.

Parameters:
RESET_PC, 0, PC value loaded on reset (byte address)
MEM_DEPTH, 4000, instruction memory depth in 32-bit words; PCs at or beyond MEM_DEPTH*4 are illegal

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_PCSrc  in  1  branch/jump taken (MEM stage)
in_branch_address  in  32  redirect target, byte address
in_stall  in  1  hold request from hazard unit (load-use)
in_halt  in  1  halt instruction decoded in ID
imem_req  out  1  fetch request valid
imem_addr  out  32  word index (PC>>2), stable while imem_req=1 and not ready
imem_ready  in  1  imem_rdata valid this cycle; may assert in the same cycle as req
imem_rdata  in  32  fetched instruction
instruction_out  out  32  IF/ID instruction
pc_plus_four_out  out  32  IF/ID PC+4
if_id_valid  out  1  IF/ID holds a real instruction; 0 = bubble
pc_out  out  32  current PC
halted  out  1  controller in HALT
fault  out  1  controller in FAULT
fetch_count  out  32  instructions delivered to IF/ID since reset; wraps

Behaviour:
- Reset (rst=1 at clock edge): PC=RESET_PC, state=IDLE. All outputs 0 except pc_out=RESET_PC. Holding buffer cleared. Reset overrides everything, including mid-request; an imem_ready in that cycle is ignored.
- States: IDLE, FETCH, HOLD, HALT, FAULT.
- IDLE: imem_req=0; moves to FETCH next cycle unconditionally.
- FETCH:
  - imem_req=1 iff pc_ok, where pc_ok = PC[1:0]==0 and PC < MEM_DEPTH*4.
  - imem_addr=PC>>2.
  - If !pc_ok: next state FAULT, IF/ID valid cleared.
- Event priority each cycle, for FETCH and HOLD: in_PCSrc > in_halt > in_stall > normal.
  - in_PCSrc=1: PC<=in_branch_address; if_id_valid<=0; instruction_out<=0; buffer discarded; any ready this cycle ignored; next state FETCH. Target legality is checked in the following FETCH cycle.
  - in_halt=1: if_id_valid<=0; next state HALT; PC holds.
  - in_stall=1: IF/ID and PC hold. In FETCH with imem_ready=1, imem_rdata is captured into the holding buffer and the next state is HOLD; otherwise stay in FETCH with the request held.
  - Normal in FETCH, imem_ready=1: IF/ID <= {imem_rdata, PC+4, 1}; PC<=PC+4; fetch_count++.
  - Normal in FETCH, imem_ready=0: if_id_valid<=0 (bubble); request held.
  - Normal in HOLD: IF/ID <= {buffer, PC+4, 1}; PC<=PC+4; fetch_count++; next state FETCH. imem_req=0 in HOLD.
- Throughput: one instruction per cycle with zero-latency memory. Latency from PC update to IF/ID = 1 cycle when ready is in the same cycle.
- HALT: imem_req=0, halted=1, IF/ID invalid. Exit only via rst.
- FAULT: imem_req=0, fault=1, IF/ID invalid, pc_out shows the offending PC. Exit only via rst.
- Arithmetic: PC+4 is modulo 2^32. fetch_count wraps from 0xFFFFFFFF to 0.

Decomposition:
- Package fetch_pkg holds the state enum (IDLE, FETCH, HOLD, HALT, FAULT), the NOP constant 32'h0 and WORD_BYTES=4.
- One sub-module, fetch_if_id_reg: the IF/ID register plus holding buffer, with load/hold/flush controls.
- The state machine and PC stay in fetch_controller.

Test Plan:
1. Reset, zero-latency memory with mem[i]=i+0x100, no stalls. Required: IDLE for 1 cycle; then IF/ID shows 0x100/4, 0x101/8, 0x102/12 on consecutive cycles; fetch_count=3.
2. Memory latency 2 cycles. Required: imem_addr stays at 0 while ready=0, bubbles appear on if_id_valid, and the instruction lands on the ready cycle.
3. in_stall=1 for 3 cycles while ready arrives at PC=8. Required: IF/ID frozen; state HOLD; PC=8; after release, IF/ID = mem[2] with PC+4=12; PC=12; no re-request of address 2.
4. in_PCSrc=1 with target 0x40 in the same cycle as ready and in_stall=1. Required: ready data dropped; if_id_valid=0; next imem_addr=0x10.
5. in_halt=1. Required: halted=1 next cycle; imem_req=0; PC frozen. rst then gives PC=0 and halted=0.
6. Redirect to 0x42, and separately to 0x3E80 with MEM_DEPTH=4000. Required: fault=1 one cycle after FETCH entry; imem_req never asserted; pc_out=0x42 (resp. 0x3E80).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StHold,
        StHalt,
        StFault
    } fetch_state_e;

    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response bundle between fetch controller and imem.
interface fetch_controller_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register plus a one-word holding buffer for data that arrives
// while the pipeline is stalled.
module fetch_if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,          // write a new valid instruction
    input  logic        load_from_buf_i, // source the load from the holding buffer
    input  logic        capture_i,       // store rdata_i into the holding buffer
    input  logic        flush_i,         // redirect: invalidate, zero instr, drop buffer
    input  logic        bubble_i,        // invalidate only
    input  logic [31:0] rdata_i,
    input  logic [31:0] pc_plus_four_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus_four_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_q, buf_d;

    // Next-state selection; flush dominates load, load dominates bubble.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        buf_d   = buf_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP;
            buf_d   = NOP;
        end else if (load_i) begin
            instr_d = load_from_buf_i ? buf_q : rdata_i;
            pc4_d   = pc_plus_four_i;
            valid_d = 1'b1;
        end else if (bubble_i) begin
            valid_d = 1'b0;
        end
        if (!flush_i && capture_i) begin
            buf_d = rdata_i;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            buf_q   <= NOP;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
        end
    end

    assign instr_o        = instr_q;
    assign pc_plus_four_o = pc4_q;
    assign valid_o        = valid_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, issues imem requests and applies
// redirect/halt/stall decisions before loading the IF/ID register.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 4000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_PCSrc,
    input  logic [31:0]               in_branch_address,
    input  logic                      in_stall,
    input  logic                      in_halt,
    fetch_controller_if.master        imem,
    output logic [31:0]               instruction_out,
    output logic [31:0]               pc_plus_four_out,
    output logic                      if_id_valid,
    output logic [31:0]               pc_out,
    output logic                      halted,
    output logic                      fault,
    output logic [31:0]               fetch_count
);

    // First illegal byte address; 33 bits so large depths cannot overflow.
    localparam logic [32:0] PcLimit = 33'(MEM_DEPTH) << 2;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  count_q, count_d;

    logic        pc_ok;
    logic [31:0] pc_plus_four;
    logic        ifid_load, ifid_from_buf, ifid_capture, ifid_flush, ifid_bubble;

    assign pc_ok        = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} < PcLimit);
    assign pc_plus_four = pc_q + 32'(WORD_BYTES);

    // Next-state, PC and IF/ID control decode; redirect > halt > stall > normal.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        count_d       = count_q;
        ifid_load     = 1'b0;
        ifid_from_buf = 1'b0;
        ifid_capture  = 1'b0;
        ifid_flush    = 1'b0;
        ifid_bubble   = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (!pc_ok) begin
                    ifid_bubble = 1'b1;
                    state_d     = StFault;
                end else if (in_PCSrc) begin
                    pc_d       = in_branch_address;
                    ifid_flush = 1'b1;
                end else if (in_halt) begin
                    ifid_bubble = 1'b1;
                    state_d     = StHalt;
                end else if (in_stall) begin
                    if (imem.imem_ready) begin
                        ifid_capture = 1'b1;
                        state_d      = StHold;
                    end
                end else if (imem.imem_ready) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus_four;
                    count_d   = count_q + 32'd1;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            StHold: begin
                if (in_PCSrc) begin
                    pc_d       = in_branch_address;
                    ifid_flush = 1'b1;
                    state_d    = StFetch;
                end else if (in_halt) begin
                    ifid_bubble = 1'b1;
                    state_d     = StHalt;
                end else if (!in_stall) begin
                    ifid_load     = 1'b1;
                    ifid_from_buf = 1'b1;
                    pc_d          = pc_plus_four;
                    count_d       = count_q + 32'd1;
                    state_d       = StFetch;
                end
            end
            StHalt, StFault: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, PC and delivery counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    fetch_if_id_reg u_if_id (
        .clk             (clk),
        .rst             (rst),
        .load_i          (ifid_load),
        .load_from_buf_i (ifid_from_buf),
        .capture_i       (ifid_capture),
        .flush_i         (ifid_flush),
        .bubble_i        (ifid_bubble),
        .rdata_i         (imem.imem_rdata),
        .pc_plus_four_i  (pc_plus_four),
        .instr_o         (instruction_out),
        .pc_plus_four_o  (pc_plus_four_out),
        .valid_o         (if_id_valid)
    );

    assign imem.imem_req  = (state_q == StFetch) && pc_ok;
    assign imem.imem_addr = (state_q == StFetch) ? {2'b00, pc_q[31:2]} : 32'h0;
    assign pc_out         = pc_q;
    assign halted         = (state_q == StHalt);
    assign fault          = (state_q == StFault);
    assign fetch_count    = count_q;

endmodule
